// File: rtl/audio_frame_fifo.sv
// -----------------------------------------------------------------------------
// audio_frame_fifo
//   Stereo frame FIFO between the bus-side register block and the I2S master.
//   Stores DEPTH frames of {left, right} 24-bit samples. Pushes are accepted
//   while not full; refused pushes set a sticky overflow flag. Pops are paced
//   to at most one frame every two clocks so the downstream out_full flag has
//   a cycle to update after each write strobe.
//
//   DEPTH must be a power of two in the range 4..256.
//
//   Optional feature macro: AUDIO_FIFO_GAIN_EN
//     defined   : per-channel Q1.7 gain with saturation in the output stage
//     undefined : samples pass bit-exact, gain inputs are ignored
// -----------------------------------------------------------------------------
module audio_frame_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [23:0]              in_l,
   input  logic [23:0]              in_r,
   input  logic                     in_valid,
   output logic                     in_full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clear_flags,
   input  logic [7:0]               gain_l,
   input  logic [7:0]               gain_r,
   output logic [23:0]              out_l,
   output logic [23:0]              out_r,
   output logic                     out_write,
   input  logic                     out_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [47:0]   mem [DEPTH];
   logic [47:0]   rd_data;
   logic          push;
   logic          pop;
   logic          drop;
   logic [23:0]   out_l_next;
   logic [23:0]   out_r_next;

   // Full is derived from the registered level only, so a push at full is
   // refused even when a pop happens in the same cycle.
   assign in_full = (level == LW'(DEPTH));
   assign push    = in_valid && !in_full;
   assign drop    = in_valid && in_full;
   // A pop is blocked in the cycle where out_write is high, giving the I2S
   // master one cycle to reflect the new frame in out_full.
   assign pop     = (level != '0) && !out_full && !out_write;
   assign rd_data = mem[rd_ptr];

`ifdef AUDIO_FIFO_GAIN_EN
   // Signed 24x9 multiply (gain zero-extended), arithmetic shift by 7,
   // saturation to the 24-bit signed range.
   function automatic logic [23:0] apply_gain(input logic [23:0] sample,
                                              input logic [7:0]  gain);
      logic signed [32:0] prod;
      logic signed [32:0] shifted;
      prod    = $signed(sample) * $signed({1'b0, gain});
      shifted = prod >>> 7;
      if (shifted > 33'sd8388607)
         return 24'h7F_FFFF;
      else if (shifted < -33'sd8388608)
         return 24'h80_0000;
      else
         return shifted[23:0];
   endfunction
`else
   logic unused_gain;
   assign unused_gain = ^{gain_l, gain_r};
`endif

   // Output-stage data path: gain (optional) applied to the frame being popped.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      out_l_next = rd_data[47:24];
      out_r_next = rd_data[23:0];
`ifdef AUDIO_FIFO_GAIN_EN
      out_l_next = apply_gain(rd_data[47:24], gain_l);
      out_r_next = apply_gain(rd_data[23:0],  gain_r);
`endif
   end

   // Frame storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; level and pointers define which
      // entries are meaningful, so stale contents are never observed.
      if (push)
         mem[wr_ptr] <= {in_l, in_r};
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Sticky overflow: a refused push wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
      else if (clear_flags)
         overflow <= 1'b0;
   end

   // Registered output frame and write strobe towards the I2S master.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_write <= 1'b0;
         out_l     <= '0;
         out_r     <= '0;
      end else begin
         out_write <= pop;
         if (pop) begin
            out_l <= out_l_next;
            out_r <= out_r_next;
         end
      end
   end

endmodule

// File: tb/tb_audio_frame_fifo.sv
// -----------------------------------------------------------------------------
// tb_audio_frame_fifo
//   Directed bench for audio_frame_fifo (DEPTH = 16). Inputs are driven and
//   outputs sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_audio_frame_fifo;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] in_l;
   logic [23:0] in_r;
   logic        in_valid;
   logic        in_full;
   logic [4:0]  level;
   logic        overflow;
   logic        clear_flags;
   logic [7:0]  gain_l;
   logic [7:0]  gain_r;
   logic [23:0] out_l;
   logic [23:0] out_r;
   logic        out_write;
   logic        out_full;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   audio_frame_fifo #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_l        (in_l),
      .in_r        (in_r),
      .in_valid    (in_valid),
      .in_full     (in_full),
      .level       (level),
      .overflow    (overflow),
      .clear_flags (clear_flags),
      .gain_l      (gain_l),
      .gain_r      (gain_r),
      .out_l       (out_l),
      .out_r       (out_r),
      .out_write   (out_write),
      .out_full    (out_full)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int          idx;
      logic        prev_wr;
      logic        back_to_back;
      logic        any_write;
      logic [23:0] exp_r;

      reset       = 1'b1;
      in_l        = '0;
      in_r        = '0;
      in_valid    = 1'b0;
      clear_flags = 1'b0;
      gain_l      = 8'h80;
      gain_r      = 8'h80;
      out_full    = 1'b0;

      // ---- reset state ----
      step();
      step();
      check("rst_level",    48'(level),     48'd0);
      check("rst_in_full",  48'(in_full),   48'd0);
      check("rst_overflow", 48'(overflow),  48'd0);
      check("rst_out_write",48'(out_write), 48'd0);
      check("rst_out_data", {out_l, out_r}, 48'd0);
      reset = 1'b0;
      step();

      // ---- single frame, minimum latency ----
      in_l     = 24'h123456;
      in_r     = 24'hFEDCBA;
      in_valid = 1'b1;
      step();                                   // push edge N
      in_valid = 1'b0;
      check("lat_level_1",   48'(level),     48'd1);
      check("lat_wr_early",  48'(out_write), 48'd0);
      step();                                   // edge N+1: pop registered
      check("lat_wr_high",   48'(out_write), 48'd1);
      check("lat_data",      {out_l, out_r}, 48'h123456_FEDCBA);
      check("lat_level_0",   48'(level),     48'd0);
      step();
      check("lat_wr_low",    48'(out_write), 48'd0);
      check("lat_data_hold", {out_l, out_r}, 48'h123456_FEDCBA);

      // ---- fill with downstream stalled, one extra push overflows ----
      out_full  = 1'b1;
      any_write = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         in_l     = 24'h100000 + 24'(i);
         in_r     = 24'h200000 + 24'(i);
         in_valid = 1'b1;
         step();
         any_write |= out_write;
      end
      check("fill_level",    48'(level),    48'(DEPTH));
      check("fill_in_full",  48'(in_full),  48'd1);
      check("fill_no_ovf",   48'(overflow), 48'd0);
      in_l = 24'h3BAD00;
      in_r = 24'h3BAD01;
      step();                                   // refused push
      in_valid = 1'b0;
      any_write |= out_write;
      check("ovf_set",       48'(overflow),  48'd1);
      check("ovf_level",     48'(level),     48'(DEPTH));
      check("stall_no_write",48'(any_write), 48'd0);

      // ---- clear_flags behaviour ----
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      check("clr_alone",     48'(overflow), 48'd0);
      clear_flags = 1'b1;
      in_valid    = 1'b1;
      step();                                   // refused push beats clear
      clear_flags = 1'b0;
      in_valid    = 1'b0;
      check("clr_vs_ovf",    48'(overflow), 48'd1);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      check("clr_again",     48'(overflow), 48'd0);

      // ---- push at full refused even with same-cycle pop ----
      out_full = 1'b0;
      in_l     = 24'h3DEAD0;
      in_r     = 24'h3DEAD1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("fullpop_level", 48'(level),     48'(DEPTH - 1));
      check("fullpop_ovf",   48'(overflow),  48'd1);
      check("fullpop_wr",    48'(out_write), 48'd1);
      check("drain_0",       {out_l, out_r}, 48'h100000_200000);

      // ---- drain across pointer wrap, in order, never back to back ----
      idx          = 1;
      prev_wr      = 1'b1;
      back_to_back = 1'b0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (out_write && prev_wr)
            back_to_back = 1'b1;
         if (out_write) begin
            check($sformatf("drain_%0d", idx), {out_l, out_r},
                  {24'h100000 + 24'(idx), 24'h200000 + 24'(idx)});
            idx++;
         end
         prev_wr = out_write;
      end
      check("drain_count",   48'(idx),          48'(DEPTH));
      check("drain_spacing", 48'(back_to_back), 48'd0);
      check("drain_level",   48'(level),        48'd0);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;

      // ---- reset with stored frames ----
      out_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_l     = 24'h400000 + 24'(i);
         in_r     = 24'h500000 + 24'(i);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      check("pre_rst_level", 48'(level), 48'd5);
      reset    = 1'b1;
      out_full = 1'b0;
      step();
      check("mid_rst_level", 48'(level),     48'd0);
      check("mid_rst_wr",    48'(out_write), 48'd0);
      reset     = 1'b0;
      any_write = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         any_write |= out_write;
      end
      check("no_stale_frame",48'(any_write), 48'd0);
      check("post_rst_level",48'(level),     48'd0);

      // ---- fresh frame after reset ----
      in_l     = 24'h0ABCDE;
      in_r     = 24'h0EDCBA;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("post_rst_wr",   48'(out_write), 48'd1);
      check("post_rst_data", {out_l, out_r}, 48'h0ABCDE_0EDCBA);
      step();

      // ---- gain stage (pass-through when the feature is compiled out) ----
      gain_l   = 8'hFF;
      gain_r   = 8'h40;
      in_l     = 24'h7FFFFF;
      in_r     = 24'h800000;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
`ifdef AUDIO_FIFO_GAIN_EN
      exp_r = 24'hC00000;
`else
      exp_r = 24'h800000;
`endif
      check("gain_wr",       48'(out_write), 48'd1);
      check("gain_out_l",    48'(out_l),     48'h7FFFFF);
      check("gain_out_r",    48'(out_r),     48'(exp_r));
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/audio_frame_fifo.md
AUDIO_FRAME_FIFO -- requirements
Module: audio_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, frame capacity; power of two, range 4..256.
REQ-002 SHALL have port clk, input, 1 bit, the SoC clock (clk_soc domain); all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port in_l, input, 24 bits, left sample from the bus-side register block, signed two's complement.
REQ-005 SHALL have port in_r, input, 24 bits, right sample, signed two's complement.
REQ-006 SHALL have port in_valid, input, 1 bit, one-cycle push strobe for {in_l, in_r}.
REQ-007 SHALL have port in_full, output, 1 bit, high when level == DEPTH.
REQ-008 SHALL have port level, output, log2(DEPTH)+1 bits, number of stored frames.
REQ-009 SHALL have port overflow, output, 1 bit, sticky flag for a dropped push.
REQ-010 SHALL have port clear_flags, input, 1 bit, one-cycle pulse that clears overflow.
REQ-011 SHALL have port gain_l, input, 8 bits, unsigned Q1.7 left gain (0x80 = unity).
REQ-012 SHALL have port gain_r, input, 8 bits, unsigned Q1.7 right gain.
REQ-013 SHALL have port out_l, output, 24 bits, left frame to the I2S master frame_in_l.
REQ-014 SHALL have port out_r, output, 24 bits, right frame to the I2S master frame_in_r.
REQ-015 SHALL have port out_write, output, 1 bit, one-cycle strobe to the I2S master write_frame.
REQ-016 SHALL have port out_full, input, 1 bit, full flag from the I2S master; no pop while high.

Function
REQ-017 SHALL implement a circular buffer of DEPTH 48-bit entries with write and read pointers that wrap modulo DEPTH.
REQ-018 SHALL accept a push when in_valid=1 and in_full=0; level increments at the next edge.
REQ-019 SHALL, on in_valid=1 while in_full=1, discard the frame, leave pointers unchanged and set overflow.
REQ-020 SHALL evaluate in_full from the registered level only; a push at full SHALL be refused even if a pop occurs in the same cycle.
REQ-021 SHALL pop one frame when level>0 and out_full=0; out_l, out_r and out_write SHALL be registered and valid in the cycle after the pop decision.
REQ-022 SHALL hold out_write low in cycles without a pop; out_l/out_r SHALL hold the last popped values.
REQ-023 SHALL NOT pop on consecutive cycles; after each out_write pulse it SHALL wait one cycle so out_full from the downstream has updated (maximum one frame per 2 clocks).
REQ-024 SHALL have minimum latency, push to out_write, of 2 cycles (empty FIFO, out_full=0): push at edge N, pop decision in cycle N+1, out_write high in cycle N+2.
REQ-025 SHALL, on simultaneous push and pop with 0<level<DEPTH, leave level unchanged.
REQ-026 SHALL give clear_flags priority lower than a same-cycle overflow event, so overflow stays 1.
REQ-027 SHALL ignore gain_l/gain_r when AUDIO_FIFO_GAIN_EN is undefined.

Reset
REQ-028 SHALL, on reset=1 at a clk edge, set level=0, both pointers=0, in_full=0, overflow=0, out_write=0, out_l=0 and out_r=0.
REQ-029 SHALL, on reset mid-operation, lose all stored frames and emit no out_write in the cycle after reset.
REQ-030 SHALL not require the storage array contents to be reset.

Configuration
REQ-031 SHALL, with macro AUDIO_FIFO_GAIN_EN defined, compute out = sat24((sample * gain) >>> 7) per channel: signed 24x9 multiply with gain zero-extended, arithmetic shift, saturation to -8388608..8388607, all within the output register stage so latency is unchanged.
REQ-032 SHALL, with AUDIO_FIFO_GAIN_EN undefined, pass samples bit-exact and infer no multiplier.

Verification
REQ-033 SHALL cover: reset, push L=0x123456 R=0xFEDCBA, out_full=0 -> out_write high exactly 2 cycles after the push edge with identical data; level returns to 0.
REQ-034 SHALL cover: out_full=1, push DEPTH+1 frames -> level=DEPTH, in_full=1, overflow=1; the last frame is never output.
REQ-035 SHALL cover: release out_full after fill -> DEPTH out_write pulses at most one per 2 cycles, in push order, across pointer wrap.
REQ-036 SHALL cover: clear_flags pulse with no overflow in the same cycle -> overflow=0 next cycle; clear_flags coincident with a refused push -> overflow stays 1.
REQ-037 SHALL cover: reset asserted with level=5 -> level=0, out_write=0 next cycle, no stale frame is emitted afterwards.
REQ-038 SHALL cover, with AUDIO_FIFO_GAIN_EN defined: gain 0xFF, L=0x7FFFFF -> out_l=0x7FFFFF (saturated); gain 0x40, R=0x800000 -> out_r=0xC00000.
